// File: rtl/issue_stage.sv
// Operand-fetch/issue stage: busy scoreboard, RAW/WAW stall, registered issue slot.
// Optional ISSUE_STAGE_PERF_EN adds stat_issued / stat_raw_stall counters.
module issue_stage #(
    parameter int WIDTH  = 64,
    parameter int NREGS  = 32,
    parameter int NWRITE = 1,
    parameter int UOPW   = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [AW-1:0]                  in_rs1,
    input  logic [AW-1:0]                  in_rs2,
    input  logic [AW-1:0]                  in_rd,
    input  logic                           in_rd_we,
    input  logic [UOPW-1:0]                in_uop,
    output logic [1:0][AW-1:0]             rf_raddr,
    input  logic [1:0][WIDTH-1:0]          rf_rdata,
    input  logic [NWRITE-1:0]              wb_valid,
    input  logic [NWRITE-1:0][AW-1:0]      wb_rd,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_op1,
    output logic [WIDTH-1:0]               out_op2,
    output logic [AW-1:0]                  out_rd,
    output logic                           out_rd_we,
    output logic [UOPW-1:0]                out_uop
`ifdef ISSUE_STAGE_PERF_EN
    ,
    output logic [31:0]                    stat_issued,
    output logic [31:0]                    stat_raw_stall
`endif
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [NREGS-1:0] wb_hit;
    logic [NREGS-1:0] eff_busy;
    logic             hazard;
    logic             accept;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic             rd_we_q, rd_we_d;
    logic [UOPW-1:0]  uop_q, uop_d;

    assign rf_raddr[0] = in_rs1;
    assign rf_raddr[1] = in_rs2;

    // Same-cycle writeback hides busy, matching the register file bypass.
    always_comb begin
        wb_hit = '0;
        for (int w = 0; w < NWRITE; w++) begin
            if (wb_valid[w]) wb_hit[wb_rd[w]] = 1'b1;
        end
    end

    assign eff_busy = busy_q & ~wb_hit;
    assign hazard   = eff_busy[in_rs1] | eff_busy[in_rs2]
                    | (in_rd_we & eff_busy[in_rd]);
    assign in_ready = ~hazard & ~flush & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        busy_d = busy_q & ~wb_hit;
        if (accept && in_rd_we) busy_d[in_rd] = 1'b1;
        busy_d[0] = 1'b0;
        if (flush) busy_d = '0;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        rd_d        = rd_q;
        rd_we_d     = rd_we_q;
        uop_d       = uop_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            op1_d       = rf_rdata[0];
            op2_d       = rf_rdata[1];
            rd_d        = in_rd;
            rd_we_d     = in_rd_we;
            uop_d       = in_uop;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            rd_q        <= '0;
            rd_we_q     <= 1'b0;
            uop_q       <= '0;
        end else begin
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            rd_q        <= rd_d;
            rd_we_q     <= rd_we_d;
            uop_q       <= uop_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_op1   = op1_q;
    assign out_op2   = op2_q;
    assign out_rd    = rd_q;
    assign out_rd_we = rd_we_q;
    assign out_uop   = uop_q;

`ifdef ISSUE_STAGE_PERF_EN
    logic [31:0] issued_q, issued_d;
    logic [31:0] stall_q, stall_d;

    // Counters survive flush; only reset clears them.
    always_comb begin
        issued_d = issued_q + {31'd0, accept};
        stall_d  = stall_q + {31'd0, in_valid & hazard & ~flush};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            issued_q <= issued_d;
            stall_q  <= stall_d;
        end
    end

    assign stat_issued    = issued_q;
    assign stat_raw_stall = stall_q;
`endif

endmodule

// File: tb/tb_issue_stage.sv
// Randomized scoreboard bench for issue_stage against an in-flight-list model.
// Perf counter checks are compiled when ISSUE_STAGE_PERF_EN is defined.
module tb_issue_stage;

    localparam int W  = 64;
    localparam int NR = 32;
    localparam int NW = 1;
    localparam int UW = 16;
    localparam int AW = 5;

    typedef struct {
        logic [W-1:0]  op1;
        logic [W-1:0]  op2;
        logic [AW-1:0] rd;
        logic          we;
        logic [UW-1:0] uop;
    } item_t;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic                  flush = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [AW-1:0]         in_rs1 = '0;
    logic [AW-1:0]         in_rs2 = '0;
    logic [AW-1:0]         in_rd = '0;
    logic                  in_rd_we = 1'b0;
    logic [UW-1:0]         in_uop = '0;
    logic [1:0][AW-1:0]    rf_raddr;
    logic [1:0][W-1:0]     rf_rdata = '0;
    logic [NW-1:0]         wb_valid = '0;
    logic [NW-1:0][AW-1:0] wb_rd = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [W-1:0]          out_op1;
    logic [W-1:0]          out_op2;
    logic [AW-1:0]         out_rd;
    logic                  out_rd_we;
    logic [UW-1:0]         out_uop;
`ifdef ISSUE_STAGE_PERF_EN
    logic [31:0]           stat_issued;
    logic [31:0]           stat_raw_stall;
`endif

    issue_stage #(.WIDTH(W), .NREGS(NR), .NWRITE(NW), .UOPW(UW)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rd_we(in_rd_we), .in_uop(in_uop),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
        .out_rd_we(out_rd_we), .out_uop(out_uop)
`ifdef ISSUE_STAGE_PERF_EN
        ,
        .stat_issued(stat_issued), .stat_raw_stall(stat_raw_stall)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: destinations of issued-but-not-written-back ops, plus slot contents.
    logic [AW-1:0] inflight[$];
    item_t         exp_q[$];
    bit            slot_full = 1'b0;
    bit            started = 1'b0;
    bit            step = 1'b0;
    bit            acc = 1'b0;
    bit            cur_rst = 1'b0;
    bit            chk_zero = 1'b0;
    int unsigned   n_iss = 0;
    int unsigned   n_stall = 0;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pending(input logic [AW-1:0] r);
        bit hit = 1'b0;
        foreach (inflight[k]) if (inflight[k] == r) hit = 1'b1;
        if (wb_valid[0] && wb_rd[0] == r) hit = 1'b0;
        return hit;
    endfunction

    task automatic apply();
        item_t it;
        if (!step) return;
        if (cur_rst || flush) begin
            inflight.delete();
            if (slot_full && exp_q.size() > 0) exp_q.delete(0);
            slot_full = 1'b0;
            if (cur_rst) begin
                n_iss   = 0;
                n_stall = 0;
            end
        end else begin
            if (wb_valid[0]) begin
                for (int k = 0; k < inflight.size(); k++) begin
                    if (inflight[k] == wb_rd[0]) begin
                        inflight.delete(k);
                        break;
                    end
                end
            end
            if (acc) begin
                if (in_rd_we && in_rd != 0) inflight.push_back(in_rd);
                it.op1 = rf_rdata[0];
                it.op2 = rf_rdata[1];
                it.rd  = in_rd;
                it.we  = in_rd_we;
                it.uop = in_uop;
                exp_q.push_back(it);
                slot_full = 1'b1;
                n_iss++;
            end else if (out_ready) begin
                slot_full = 1'b0;
            end
        end
    endtask

    // Monitor: slot occupancy and contents checked on every falling edge.
    always @(negedge clk) begin
        if (started) begin
            check("out_valid", {63'd0, out_valid}, {63'd0, slot_full});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("slot_item_present", 64'd0, 64'd1);
                end else begin
                    check("out_op1", out_op1, exp_q[0].op1);
                    check("out_op2", out_op2, exp_q[0].op2);
                    check("out_rd", {59'd0, out_rd}, {59'd0, exp_q[0].rd});
                    check("out_rd_we", {63'd0, out_rd_we}, {63'd0, exp_q[0].we});
                    check("out_uop", {48'd0, out_uop}, {48'd0, exp_q[0].uop});
                    if (out_ready && !flush && rstn) exp_q.delete(0);
                end
            end
        end
    end

    initial begin
        bit hz;
        bit exp_rdy;
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        #2;
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_out_op1", out_op1, 64'd0);
        check("reset_out_op2", out_op2, 64'd0);
        check("reset_out_uop", {48'd0, out_uop}, 64'd0);
        started = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1 apply();
            #1;
            cur_rst     = (i == 1500);
            rstn        = !cur_rst;
            flush       = !cur_rst && ($urandom % 25 == 0);
            in_valid    = !cur_rst && ($urandom % 4 != 0);
            in_rs1      = AW'($urandom % 8);
            in_rs2      = AW'($urandom % 8);
            in_rd       = AW'($urandom % 8);
            in_rd_we    = 1'($urandom % 4 != 0);
            in_uop      = UW'($urandom);
            rf_rdata[0] = {$urandom, $urandom};
            rf_rdata[1] = {$urandom, $urandom};
            out_ready   = !cur_rst && !flush && ($urandom % 4 != 0);
            wb_valid[0] = 1'b0;
            wb_rd[0]    = AW'($urandom % 8);
            if (!cur_rst && inflight.size() > 0 && $urandom % 3 == 0) begin
                wb_valid[0] = 1'b1;
                wb_rd[0]    = inflight[$urandom % inflight.size()];
            end
            #2;
            if (chk_zero) begin
                check("midreset_op1", out_op1, 64'd0);
                check("midreset_rd", {59'd0, out_rd}, 64'd0);
                chk_zero = 1'b0;
            end
            if (cur_rst) chk_zero = 1'b1;
            hz = pending(in_rs1) || pending(in_rs2) || (in_rd_we && pending(in_rd));
            exp_rdy = !hz && !flush && (!slot_full || out_ready);
            acc = in_valid && exp_rdy;
            if (!cur_rst) begin
                check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
                check("rf_raddr0", {59'd0, rf_raddr[0]}, {59'd0, in_rs1});
                check("rf_raddr1", {59'd0, rf_raddr[1]}, {59'd0, in_rs2});
                if (in_valid && hz && !flush) n_stall++;
            end
            step = 1'b1;
        end
        @(posedge clk);
        #1 apply();
        #1;
        in_valid    = 1'b0;
        flush       = 1'b0;
        out_ready   = 1'b0;
        wb_valid[0] = 1'b0;
        step        = 1'b0;
`ifdef ISSUE_STAGE_PERF_EN
        check("stat_issued", {32'd0, stat_issued}, {32'd0, n_iss});
        check("stat_raw_stall", {32'd0, stat_raw_stall}, {32'd0, n_stall});
`endif
        @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/issue_stage.md
# issue_stage

Single-issue operand-fetch and issue stage sitting directly upstream of the integer execute units and in front of the register file's read ports. It accepts decoded micro-ops, tracks pending destination writes in a per-register busy scoreboard, and stalls on RAW/WAW hazards. It reads both source operands through the register file's combinational read ports (write-bypass included) and presents the micro-op with operands in a registered valid/ready output slot.

## Interface
- WIDTH, 64, operand data width (matches register file)
- NREGS, 32, architectural registers; AW = $clog2(NREGS)
- NWRITE, 1, writeback ports (matches register file write ports)
- UOPW, 16, opaque micro-op payload width carried alongside operands
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- flush  in  1  pipeline flush: drop output slot, clear whole scoreboard
- in_valid  in  1  decoded micro-op valid
- in_ready  out  1  stage can accept this cycle
- in_rs1, in_rs2  in  AW each  source register indices
- in_rd  in  AW  destination index
- in_rd_we  in  1  micro-op writes in_rd
- in_uop  in  UOPW  payload
- rf_raddr  out  [2][AW]  register file read addresses: [0]=in_rs1, [1]=in_rs2 (combinational passthrough)
- rf_rdata  in  [2][WIDTH]  register file read data, same cycle
- wb_valid  in  NWRITE  writeback strobes (same signals driving the register file we)
- wb_rd  in  [NWRITE][AW]  writeback indices
- out_valid  out  1  issued micro-op valid
- out_ready  in  1  execute accepts
- out_op1, out_op2  out  WIDTH each  captured operands
- out_rd, out_rd_we, out_uop  out  AW/1/UOPW  forwarded fields

## Operation
- Scoreboard: NREGS busy bits; bit 0 is hardwired 0.
- Effective busy(r) = busy[r] && !(any wb_valid[w] && wb_rd[w]==r). This is the same-cycle writeback clear, consistent with register file bypass.
- hazard = (eff_busy(in_rs1) || eff_busy(in_rs2) || (in_rd_we && eff_busy(in_rd))).
- in_ready = !hazard && !flush && (!out_valid || out_ready).
- Accept = in_valid && in_ready. On accept, the output slot loads rf_rdata[0/1] and the in_* fields, and out_valid<=1.
- On accept with in_rd_we && in_rd!=0, busy[in_rd]<=1.
- Writeback: busy[wb_rd[w]]<=0 for each valid port. Set on accept and clear on writeback for the same register in the same cycle: set wins.
- When out_valid && out_ready && !accept: out_valid<=0. When out_valid && !out_ready: the slot holds and all out_* stay stable.
- flush: out_valid<=0 and all busy<=0 next cycle; no accept that cycle. flush has priority over writeback and accept.
- Reset: out_valid=0, busy=all 0, out_op1/out_op2/out_rd/out_rd_we/out_uop=0; in_ready=1 after reset deasserts (combinational).

## Timing
- Latency: accept in cycle N → out_valid in N+1 with operands as read in cycle N.
- Back-to-back: when out_ready=1 every cycle and there are no hazards, one micro-op issues per cycle.
- RAW on the immediately preceding instruction stalls until its writeback strobe. Issue proceeds in the writeback cycle itself; operands come via register file bypass.
- in_valid may drop without acceptance; the stage keeps no input state.
- Reset mid-operation: behaves as flush plus zeroing of out_* data.

## Configuration
- ISSUE_STAGE_PERF_EN defined: two extra outputs, stat_issued [31:0] (increments per accept) and stat_raw_stall [31:0] (increments in each cycle with in_valid && hazard && !flush). Both reset to 0, wrap at 2^32, and are unaffected by flush.
- Undefined: the ports and counters are absent; the remaining behaviour is identical.

## Test plan
- Reset, then in_valid with rs1=3, rs2=4, rd=5, rd_we=1; rf_rdata={0x11,0x22} → next cycle out_valid=1, op1=0x11, op2=0x22, out_rd=5; busy[5]=1.
- Issue rd=5, then rs1=5: second op stalls (in_ready=0). Assert wb_valid, wb_rd=5 in cycle k → accepted in cycle k, out_valid in k+1.
- Write rd=0 with rd_we=1 → busy[0] stays 0; a following rs1=0 issues without stall.
- out_ready=0 for 3 cycles with out_valid=1 → in_ready=0 and out_* stable; out_ready=1 → new op accepted in the same cycle.
- Outstanding busy on 5 and 7; flush → next cycle out_valid=0, rs1=7 issues immediately.
- Same-cycle accept (rd=9) and wb_rd=9 → busy[9]=1 afterwards. With ISSUE_STAGE_PERF_EN, 4 stalled cycles give stat_raw_stall=4.
